// File: rtl/game_sequencer.sv
// Game-flow controller for the LED-matrix Flappy Bird: sequences idle, countdown,
// play, dying and game-over, and produces the datapath tick enables.
module game_sequencer #(
  parameter int SEC_PERIOD   = 50_000_000,
  parameter int COUNT_SECS   = 3,
  parameter int GRAV_PERIOD  = 6_250_000,
  parameter int PIPE_BASE    = 12_500_000,
  parameter int PIPE_STEP    = 1_000_000,
  parameter int PIPE_MIN     = 4_000_000,
  parameter int GEN_RATIO    = 4,
  parameter int LVL_SHIFT    = 3,
  parameter int DYING_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tap,
  input  logic       hit,
  input  logic [9:0] score,
  output logic       grav_tick,
  output logic       pipe_tick,
  output logic       gen_tick,
  output logic       flap,
  output logic       clear_field,
  output logic       gameover,
  output logic       freeze,
  output logic [3:0] countdown,
  output logic [3:0] level,
  output logic [2:0] state
);

  localparam int SW = $clog2(SEC_PERIOD) + 1;
  localparam int GW = $clog2(GRAV_PERIOD) + 1;
  localparam int PW = $clog2(PIPE_BASE) + 1;
  localparam int RW = $clog2(GEN_RATIO) + 1;
  localparam int DW = $clog2(DYING_CYCLES) + 1;

  localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_PERIOD - 1);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_PERIOD - 1);
  localparam logic [RW-1:0] GEN_LAST  = RW'(GEN_RATIO - 1);
  localparam logic [DW-1:0] DY_LAST   = DW'(DYING_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t        st;
  logic [SW-1:0] sec_cnt;
  logic [GW-1:0] grav_cnt;
  logic [PW-1:0] pipe_cnt;
  logic [PW-1:0] cur_period;
  logic [RW-1:0] gen_cnt;
  logic [DW-1:0] dy_cnt;
  logic [9:0]    lvl_raw;

  // Signed arithmetic so a large level cannot wrap the period past the floor.
  function automatic logic [PW-1:0] period_for(input logic [3:0] lv);
    int red;
    red = int'(lv) * PIPE_STEP;
    if (PIPE_BASE - red < PIPE_MIN) return PW'(PIPE_MIN);
    else return PW'(PIPE_BASE - red);
  endfunction

  assign state     = st;
  assign lvl_raw   = score >> LVL_SHIFT;
  assign grav_tick = (st == S_PLAY) && (grav_cnt == GRAV_LAST);
  assign pipe_tick = (st == S_PLAY) && (pipe_cnt == cur_period - PW'(1));
  assign gen_tick  = pipe_tick && (gen_cnt == GEN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= S_IDLE;
      sec_cnt     <= '0;
      grav_cnt    <= '0;
      pipe_cnt    <= '0;
      cur_period  <= '0;
      gen_cnt     <= '0;
      dy_cnt      <= '0;
      flap        <= 1'b0;
      clear_field <= 1'b0;
      gameover    <= 1'b0;
      freeze      <= 1'b0;
      countdown   <= 4'd0;
      level       <= 4'd0;
    end else begin
      clear_field <= 1'b0;
      flap        <= 1'b0;
      level       <= (lvl_raw > 10'd15) ? 4'd15 : lvl_raw[3:0];
      case (st)
        S_IDLE, S_OVER: begin
          if (tap) begin
            st          <= S_COUNT;
            clear_field <= 1'b1;
            countdown   <= 4'(COUNT_SECS);
            sec_cnt     <= '0;
            gameover    <= 1'b0;
          end
        end
        S_COUNT: begin
          if (sec_cnt == SEC_LAST) begin
            sec_cnt <= '0;
            if (countdown == 4'd1) begin
              st         <= S_PLAY;
              countdown  <= 4'd0;
              grav_cnt   <= '0;
              pipe_cnt   <= '0;
              gen_cnt    <= '0;
              cur_period <= period_for(level);
            end else begin
              countdown <= countdown - 4'd1;
            end
          end else begin
            sec_cnt <= sec_cnt + SW'(1);
          end
        end
        S_PLAY: begin
          flap     <= tap && !hit;
          grav_cnt <= grav_tick ? '0 : grav_cnt + GW'(1);
          // The period is only reloaded at an interval boundary.
          if (pipe_tick) begin
            pipe_cnt   <= '0;
            cur_period <= period_for(level);
            gen_cnt    <= (gen_cnt == GEN_LAST) ? '0 : gen_cnt + RW'(1);
          end else begin
            pipe_cnt <= pipe_cnt + PW'(1);
          end
          if (hit) begin
            st     <= S_DYING;
            freeze <= 1'b1;
            dy_cnt <= '0;
          end
        end
        S_DYING: begin
          if (dy_cnt == DY_LAST) begin
            st       <= S_OVER;
            freeze   <= 1'b0;
            gameover <= 1'b1;
          end else begin
            dy_cnt <= dy_cnt + DW'(1);
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: hand-planned tick/clear/flap events per cycle are
// queued up front and matched by a monitor against what the DUT emits.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tap = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] score = 10'd0;
  logic       grav_tick, pipe_tick, gen_tick, flap, clear_field, gameover, freeze;
  logic [3:0] countdown, level;
  logic [2:0] state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Entry = {cycle, mask}; mask bits: 4 flap, 3 gen, 2 pipe, 1 grav, 0 clear.
  logic [36:0] exp_q[$];
  logic [4:0]  plan[int];

  game_sequencer #(
    .SEC_PERIOD(10), .COUNT_SECS(3), .GRAV_PERIOD(4), .PIPE_BASE(20),
    .PIPE_STEP(4), .PIPE_MIN(8), .GEN_RATIO(2), .LVL_SHIFT(3), .DYING_CYCLES(6)
  ) dut (
    .clk(clk), .reset(reset), .tap(tap), .hit(hit), .score(score),
    .grav_tick(grav_tick), .pipe_tick(pipe_tick), .gen_tick(gen_tick),
    .flap(flap), .clear_field(clear_field), .gameover(gameover),
    .freeze(freeze), .countdown(countdown), .level(level), .state(state)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  // Monitor: every cycle with an event pops the queue head
  always @(negedge clk) begin
    logic [4:0] m;
    m = {flap, gen_tick, pipe_tick, grav_tick, clear_field};
    if (m != 5'd0) begin
      if (exp_q.size() == 0) chk("unexpected_event", {32'(cyc), m}, 37'd0);
      else chk("event", {32'(cyc), m}, exp_q.pop_front());
    end
  end

  task automatic at_cycle(input int c);
    if (cyc > c) chk("schedule", 37'(cyc), 37'(c));
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void add(input int c, input logic [4:0] m);
    logic [4:0] prev;
    prev = plan.exists(c) ? plan[c] : 5'd0;
    plan[c] = prev | m;
  endfunction

  function automatic void flush_plan();
    foreach (plan[c]) exp_q.push_back({32'(c), plan[c]});
    plan.delete();
  endfunction

  task automatic pulse_tap(input int c);
    at_cycle(c);
    tap = 1'b1;
    at_cycle(c + 1);
    tap = 1'b0;
  endtask

  initial begin
    int t, p, p2;
    int pipe_offs[12];
    int gen_offs[6];
    pipe_offs = '{19, 39, 59, 79, 99, 111, 123, 135, 143, 151, 159, 167};
    gen_offs  = '{39, 79, 111, 135, 151, 167};

    // Reset values
    at_cycle(2);
    chk("rst_state", 37'(state), 37'd0);
    chk("rst_countdown", 37'(countdown), 37'd0);
    chk("rst_level", 37'(level), 37'd0);
    chk("rst_flags", 37'({gameover, freeze, clear_field, flap}), 37'd0);
    at_cycle(3);
    reset = 1'b1;

    // First game: plan every event up to the hit
    t = 6;
    p = t + 31;
    add(t + 1, 5'b00001);
    for (int k = 0; p + 3 + 4 * k <= p + 167; k++) add(p + 3 + 4 * k, 5'b00010);
    foreach (pipe_offs[i]) add(p + pipe_offs[i], 5'b00100);
    foreach (gen_offs[i]) add(p + gen_offs[i], 5'b01000);
    add(p + 51, 5'b10000);
    flush_plan();

    pulse_tap(t);
    chk("cd_first", 37'({state, countdown}), 37'({3'd1, 4'd3}));
    pulse_tap(t + 5);
    at_cycle(t + 10);
    chk("cd_3_end", 37'(countdown), 37'd3);
    at_cycle(t + 11);
    chk("cd_2", 37'(countdown), 37'd2);
    at_cycle(t + 21);
    chk("cd_1", 37'(countdown), 37'd1);
    at_cycle(t + 30);
    chk("count_last", 37'(state), 37'd1);
    at_cycle(p);
    chk("play_entry", 37'({state, countdown}), 37'({3'd2, 4'd0}));

    pulse_tap(p + 50);
    at_cycle(p + 85);
    score = 10'd16;
    at_cycle(p + 86);
    chk("level_2", 37'(level), 37'd2);
    at_cycle(p + 125);
    score = 10'd40;
    at_cycle(p + 126);
    chk("level_5", 37'(level), 37'd5);
    at_cycle(p + 153);
    score = 10'd1023;
    at_cycle(p + 154);
    chk("level_15", 37'(level), 37'd15);

    // Hit together with a tap on a cycle that also carries ticks
    at_cycle(p + 167);
    hit = 1'b1;
    tap = 1'b1;
    at_cycle(p + 168);
    hit = 1'b0;
    tap = 1'b0;
    chk("dying_entry", 37'({state, freeze, flap}), 37'({3'd3, 1'b1, 1'b0}));
    pulse_tap(p + 169);
    at_cycle(p + 173);
    chk("dying_last", 37'({state, freeze, gameover}), 37'({3'd3, 1'b1, 1'b0}));
    at_cycle(p + 174);
    chk("over", 37'({state, freeze, gameover}), 37'({3'd4, 1'b0, 1'b1}));

    // Restart from OVER, then reset in the middle of a pipe interval
    p2 = p + 207;
    add(p + 177, 5'b00001);
    add(p2 + 3, 5'b00010);
    add(p2 + 7, 5'b00010);
    flush_plan();
    at_cycle(p + 176);
    score = 10'd0;
    pulse_tap(p + 176);
    chk("restart", 37'({state, gameover, countdown}), 37'({3'd1, 1'b0, 4'd3}));
    at_cycle(p2);
    chk("play2_entry", 37'(state), 37'd2);
    at_cycle(p2 + 10);
    reset = 1'b0;
    #1;
    chk("async_rst_state", 37'(state), 37'd0);
    chk("async_rst_outs", 37'({grav_tick, pipe_tick, gen_tick, freeze, gameover, countdown}), 37'd0);
    at_cycle(p2 + 13);
    reset = 1'b1;
    at_cycle(p2 + 60);
    chk("idle_after_rst", 37'(state), 37'd0);
    chk("queue_drained", 37'(exp_q.size()), 37'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
